apb_master_arb: RTL and testbench
=================================

APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 Parameter AWD, default 16, address width of requester and APB address buses.
REQ-002 Parameter DWD, default 32, data width of requester and APB data buses.
REQ-003 Parameter TMO, default 16, maximum ACCESS-phase cycles waiting for pready before timeout (legal range 2..255).
REQ-004 pclk  input  1  single clock; all logic is rising-edge triggered.
REQ-005 reset  input  1  reset; asynchronous assertion; active-high.
REQ-006 req  input  2  per-requester transfer request; bit i belongs to requester i.
REQ-007 req_addr0, req_addr1  input  AWD each  requester transfer address.
REQ-008 req_wr  input  2  per-requester direction; 1=write, 0=read.
REQ-009 req_wdata0, req_wdata1  input  DWD each  requester write data.
REQ-010 done  output  2  one-cycle completion pulse per requester.
REQ-011 err  output  1  completion status, valid with any done bit; 1=pslverr or timeout.
REQ-012 rdata  output  DWD  read data of the last completed transfer.
REQ-013 paddr  output  AWD  APB address.
REQ-014 psel, penable, pwrite  output  1 each  APB control.
REQ-015 pwdata  output  DWD  APB write data.
REQ-016 prdata  input  DWD  APB read data.
REQ-017 pready, pslverr  input  1 each  APB slave response.

Function
REQ-018 Three-state FSM: IDLE, SETUP, ACCESS.
REQ-019 IDLE: psel=0, penable=0; SETUP: psel=1, penable=0; ACCESS: psel=1, penable=1.
REQ-020 In IDLE with any req bit high, the FSM grants one requester and moves to SETUP on the next edge; with req=00 it stays in IDLE.
REQ-021 Arbitration is round-robin: single request is granted directly; with req=11 the requester not granted last time wins.
REQ-022 The last-grant pointer resets to 1, so requester 0 wins the first contention.
REQ-023 At grant, the winner's addr, wr and wdata are captured into registers driving paddr, pwrite and pwdata, held stable through SETUP and ACCESS.
REQ-024 SETUP always lasts exactly one cycle, then ACCESS.
REQ-025 ACCESS with pready=1 completes the transfer: next state IDLE; done[grant] pulses high in the following cycle; err=pslverr sampled; rdata=prdata sampled for reads; rdata unchanged for writes.
REQ-026 ACCESS with pready=0 stays in ACCESS and increments an 8-bit wait counter, cleared on entry to ACCESS.
REQ-027 When the wait counter equals TMO-1 with pready=0, the transfer times out: next state IDLE; done[grant] pulses; err=1; rdata unchanged.
REQ-028 pready=1 in the same cycle as the timeout condition counts as normal completion, not timeout.
REQ-029 Minimum transfer is 3 cycles (grant in IDLE, SETUP, ACCESS); back-to-back transfers pass through IDLE for one cycle, so a continuously-requesting pair alternates grants.
REQ-030 Requester must hold req and its command stable until its done pulse; the cycle carrying done is an IDLE cycle, and a req still high then is treated as a new request.
REQ-031 A req deasserted while its transfer is in progress does not abort the transfer; done still pulses.
REQ-032 Exactly one done bit is high at most in any cycle; err is 0 whenever done=00.
REQ-033 paddr, pwrite and pwdata hold their last values in IDLE.

Reset
REQ-034 With reset high: FSM in IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, done=00, err=0, rdata=0, wait counter=0, last-grant=1.
REQ-035 Reset asserted mid-transfer drops that transfer immediately with no done pulse; after release, pending requests are arbitrated afresh.

Verification
REQ-036 Single write: req=01, addr0=0x0010, wr=1, wdata0=0xDEADBEEF, pready=1 at first ACCESS -> psel high 2 cycles, penable 1 cycle, done=01 pulse on 3rd cycle after grant, err=0.
REQ-037 Read with wait states: req=10, addr1=0x0020, wr=0, pready low 3 ACCESS cycles then high with prdata=0x12345678 -> ACCESS lasts 4 cycles, done=10, rdata=0x12345678, err=0.
REQ-038 Contention: req=11 held continuously after reset, pready=1 -> grants alternate 0,1,0,1; done pulses every 3 cycles.
REQ-039 Timeout: TMO=16, pready held 0 -> ACCESS lasts exactly 16 cycles, done pulses with err=1, rdata unchanged; pready=1 on 16th cycle instead -> normal completion, err=pslverr.
REQ-040 Slave error: pslverr=1 with pready=1 on a read -> done with err=1, rdata=prdata.
REQ-041 Reset mid-ACCESS: assert reset during wait states -> psel/penable low asynchronously, no done pulse; after release, req=01 yields a fresh SETUP.

Source files
------------

// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin arbitration in front of a single
// IDLE/SETUP/ACCESS APB sequencer with a bounded wait-state timeout.
module apb_master_arb #(
    parameter int AWD = 16,
    parameter int DWD = 32,
    parameter int TMO = 16
) (
    input  logic           pclk,
    input  logic           reset,
    input  logic [1:0]     req,
    input  logic [AWD-1:0] req_addr0,
    input  logic [AWD-1:0] req_addr1,
    input  logic [1:0]     req_wr,
    input  logic [DWD-1:0] req_wdata0,
    input  logic [DWD-1:0] req_wdata1,
    output logic [1:0]     done,
    output logic           err,
    output logic [DWD-1:0] rdata,
    output logic [AWD-1:0] paddr,
    output logic           psel,
    output logic           penable,
    output logic           pwrite,
    output logic [DWD-1:0] pwdata,
    input  logic [DWD-1:0] prdata,
    input  logic           pready,
    input  logic           pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_t         state_q, state_d;
    logic           grant_q, grant_d;
    logic           last_q, last_d;
    logic [7:0]     wcnt_q, wcnt_d;
    logic [AWD-1:0] paddr_q, paddr_d;
    logic           pwrite_q, pwrite_d;
    logic [DWD-1:0] pwdata_q, pwdata_d;
    logic [1:0]     done_q, done_d;
    logic           err_q, err_d;
    logic [DWD-1:0] rdata_q, rdata_d;
    logic           win_s;

    // Round-robin pick: on contention the requester not granted last time wins.
    always_comb begin
        if (req == 2'b11) begin
            win_s = ~last_q;
        end else if (req[1]) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Next-state, command capture and completion status.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        wcnt_d   = wcnt_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        done_d   = 2'b00;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    state_d  = SETUP;
                    grant_d  = win_s;
                    last_d   = win_s;
                    paddr_d  = win_s ? req_addr1 : req_addr0;
                    pwrite_d = req_wr[win_s];
                    pwdata_d = win_s ? req_wdata1 : req_wdata0;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                wcnt_d  = 8'd0;
            end
            ACCESS: begin
                // pready wins over a coincident timeout.
                if (pready) begin
                    state_d = IDLE;
                    done_d  = grant_q ? 2'b10 : 2'b01;
                    err_d   = pslverr;
                    if (!pwrite_q) begin
                        rdata_d = prdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (wcnt_q == TMO_LAST) begin
                    state_d = IDLE;
                    done_d  = grant_q ? 2'b10 : 2'b01;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            wcnt_q   <= 8'd0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            done_q   <= 2'b00;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            wcnt_q   <= wcnt_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign psel    = (state_q != IDLE);
    assign penable = (state_q == ACCESS);
    assign paddr   = paddr_q;
    assign pwrite  = pwrite_q;
    assign pwdata  = pwdata_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Randomized scoreboard bench for apb_master_arb: a transaction-level model
// predicts grant order, status and read data; a monitor checks each done pulse.
module tb_apb_master_arb;

    localparam int AWD = 16;
    localparam int DWD = 32;
    localparam int TMO = 16;

    typedef struct {
        int         w;
        logic       slverr;
        logic [31:0] prdata;
    } plan_t;

    typedef struct {
        logic [1:0]  done;
        logic        err;
        logic [31:0] rdata;
        logic [15:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          alen;
    } exp_t;

    logic           pclk = 1'b0;
    logic           reset = 1'b1;
    logic [1:0]     req = 2'b00;
    logic [AWD-1:0] req_addr0 = '0, req_addr1 = '0;
    logic [1:0]     req_wr = 2'b00;
    logic [DWD-1:0] req_wdata0 = '0, req_wdata1 = '0;
    logic [1:0]     done;
    logic           err;
    logic [DWD-1:0] rdata;
    logic [AWD-1:0] paddr;
    logic           psel, penable, pwrite;
    logic [DWD-1:0] pwdata;
    logic [DWD-1:0] prdata = '0;
    logic           pready = 1'b0;
    logic           pslverr = 1'b0;

    int    tests = 0;
    int    fails = 0;
    plan_t plan_q[$];
    exp_t  exp_q[$];
    logic  last_m = 1'b1;
    logic [31:0] rdata_m = 32'd0;

    apb_master_arb #(.AWD(AWD), .DWD(DWD), .TMO(TMO)) dut (
        .pclk(pclk), .reset(reset), .req(req),
        .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wr(req_wr),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .done(done), .err(err), .rdata(rdata),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Slave model: follows the pre-planned wait count for each transfer.
    plan_t cur;
    int    s_cnt = 0;
    initial begin
        cur = '{w: 0, slverr: 1'b0, prdata: 32'd0};
        forever begin
            @(negedge pclk);
            if (reset) begin
                s_cnt  = 0;
                pready = 1'b0;
            end else if (psel && !penable) begin
                tests++;
                if (plan_q.size() == 0) begin
                    fails++;
                    $display("FAIL plan_underflow: unexpected SETUP at %0t", $time);
                    cur = '{w: 0, slverr: 1'b0, prdata: 32'd0};
                end else begin
                    cur = plan_q.pop_front();
                end
                s_cnt  = 0;
                pready = 1'b0;
            end else if (psel && penable) begin
                s_cnt++;
                pready  = (s_cnt == cur.w + 1);
                pslverr = pready ? cur.slverr : 1'($urandom);
                prdata  = pready ? cur.prdata : $urandom;
            end else begin
                pready  = 1'b0;
                pslverr = 1'($urandom);
            end
        end
    end

    // Monitor: pops one expectation per done pulse.
    int alen = 0;
    int plen = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge pclk);
            if (reset) begin
                alen = 0;
                plen = 0;
            end else begin
                if (psel) plen++;
                if (psel && penable) alen++;
                if (done != 2'b00) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_done: got done=%b at %0t", done, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_id", 64'(done), 64'(e.done));
                        check("err", 64'(err), 64'(e.err));
                        check("rdata", 64'(rdata), 64'(e.rdata));
                        check("access_len", 64'(alen), 64'(e.alen));
                        check("psel_len", 64'(plen), 64'(e.alen + 1));
                        check("paddr", 64'(paddr), 64'(e.addr));
                        check("pwrite", 64'(pwrite), 64'(e.wr));
                        check("pwdata", 64'(pwdata), 64'(e.wdata));
                    end
                    alen = 0;
                    plen = 0;
                end else begin
                    check("err_without_done", 64'(err), 64'd0);
                end
            end
        end
    end

    function automatic plan_t gen_plan();
        plan_t p;
        int r = $urandom_range(0, 9);
        if (r <= 5)      p.w = $urandom_range(0, 3);
        else if (r == 6) p.w = TMO - 1;
        else if (r == 7) p.w = TMO;
        else if (r == 8) p.w = TMO + 3;
        else             p.w = $urandom_range(4, TMO - 2);
        p.slverr = 1'($urandom_range(0, 3) == 0);
        p.prdata = $urandom;
        return p;
    endfunction

    // Predict one transfer for requester id from its command and the slave plan.
    task automatic predict(input logic id, input plan_t p);
        exp_t e;
        logic to = (p.w >= TMO);
        e.done  = id ? 2'b10 : 2'b01;
        e.err   = to ? 1'b1 : p.slverr;
        e.addr  = id ? req_addr1 : req_addr0;
        e.wr    = req_wr[id];
        e.wdata = id ? req_wdata1 : req_wdata0;
        if (!e.wr && !to) rdata_m = p.prdata;
        e.rdata = rdata_m;
        e.alen  = to ? TMO : p.w + 1;
        plan_q.push_back(p);
        exp_q.push_back(e);
        last_m = id;
    endtask

    task automatic wait_done(input logic [1:0] pend_in, input bit drop_early);
        logic [1:0] pend = pend_in;
        int n = 0;
        while (pend != 2'b00 && n < 400) begin
            @(negedge pclk);
            n++;
            for (int i = 0; i < 2; i++) begin
                if (done[i]) begin
                    pend[i] = 1'b0;
                    req[i]  = 1'b0;
                end
            end
            if (drop_early && psel) req = 2'b00;
        end
        tests++;
        if (pend != 2'b00) begin
            fails++;
            $display("FAIL round_timeout: pending=%b after %0d cycles", pend, n);
        end
    endtask

    task automatic run_round(input logic [1:0] pat, input bit drop_early);
        logic first;
        req_addr0  = 16'($urandom);
        req_addr1  = 16'($urandom);
        req_wr     = 2'($urandom);
        req_wdata0 = $urandom;
        req_wdata1 = $urandom;
        if (pat == 2'b11) begin
            first = ~last_m;
            predict(first, gen_plan());
            predict(~first, gen_plan());
        end else begin
            predict(pat[1], gen_plan());
        end
        req = pat;
        wait_done(pat, drop_early && (pat != 2'b11));
    endtask

    initial begin
        plan_t p;
        repeat (3) @(negedge pclk);
        check("rst_psel", 64'(psel), 64'd0);
        check("rst_penable", 64'(penable), 64'd0);
        check("rst_pwrite", 64'(pwrite), 64'd0);
        check("rst_paddr", 64'(paddr), 64'd0);
        check("rst_pwdata", 64'(pwdata), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        reset = 1'b0;

        // First contention after reset must go to requester 0.
        run_round(2'b11, 1'b0);
        for (int k = 0; k < 150; k++) begin
            int r;
            repeat ($urandom_range(0, 2)) @(negedge pclk);
            r = $urandom_range(0, 2);
            run_round(r == 0 ? 2'b01 : (r == 1 ? 2'b10 : 2'b11), 1'($urandom_range(0, 3) == 0));
        end

        // Reset during ACCESS wait states drops the transfer with no done.
        @(negedge pclk);
        req_addr0  = 16'h0040;
        req_wr     = 2'b00;
        p = '{w: TMO + 10, slverr: 1'b0, prdata: 32'hA5A5A5A5};
        plan_q.push_back(p);
        req = 2'b01;
        for (int n = 0; n < 20 && !penable; n++) @(negedge pclk);
        check("pre_rst_in_access", 64'(penable), 64'd1);
        repeat (3) @(negedge pclk);
        #1 reset = 1'b1;
        #1;
        check("async_psel", 64'(psel), 64'd0);
        check("async_penable", 64'(penable), 64'd0);
        check("async_done", 64'(done), 64'd0);
        plan_q.delete();
        exp_q.delete();
        last_m  = 1'b1;
        rdata_m = 32'd0;
        repeat (2) begin
            @(negedge pclk);
            check("rst_hold_done", 64'(done), 64'd0);
            check("rst_hold_rdata", 64'(rdata), 64'd0);
        end
        req_wr     = 2'b01;
        req_wdata0 = 32'hDEADBEEF;
        predict(1'b0, '{w: 0, slverr: 1'b0, prdata: 32'h0});
        reset = 1'b0;
        @(negedge pclk);
        check("fresh_setup_psel", 64'(psel), 64'd1);
        check("fresh_setup_penable", 64'(penable), 64'd0);
        wait_done(2'b01, 1'b0);

        repeat (4) @(negedge pclk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
